disp_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 8-digit seven-segment display. Generates the 3-bit nibble select for the 8:1 nibble mux and the active-low anode enables, with a blanking gap between digits to prevent ghosting. Double-buffers the 32-bit display word so that updates take effect only at frame boundaries, which prevents tearing. Sits between the memory/datapath (word producer) and the nibble mux / hex-to-seg decoder.

---
 rtl/disp_pkg.sv | 22 ++
 rtl/disp_interval_timer.sv | 34 +++
 rtl/disp_scan_controller.sv | 127 ++++++++++++
 tb/tb_disp_scan_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the seven-segment scan controller.
// Optional build macro LZ_BLANK_EN is consumed by disp_scan_controller.
package disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NIBBLE_W   = 4;
  localparam int SEL_W      = 3;
  localparam int WORD_W     = NUM_DIGITS * NIBBLE_W;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } disp_state_t;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

  // Active-low one-cold anode pattern for the selected digit.
  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [SEL_W-1:0] s);
    return ~(NUM_DIGITS'(1) << s);
  endfunction

endpackage

// File: rtl/disp_interval_timer.sv
// Terminal-count interval counter: counts 0..limit, pulses done on the last
// count and wraps to 0 so the next interval starts cleanly.
module disp_interval_timer
  import disp_pkg::*;
#(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign done = (cnt_reg == limit);

  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (done) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/disp_scan_controller.sv
// 8-digit seven-segment scan controller with inter-digit blanking and a
// frame-synchronous double buffer. Define LZ_BLANK_EN for leading-zero blanking.
module disp_scan_controller
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_W-1:0]     data_in,
  input  logic                  data_load,
  input  logic [NUM_DIGITS-1:0] dig_en,
  output logic [SEL_W-1:0]      sel,
  output logic [WORD_W-1:0]     d_out,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  pending,
  output logic                  frame_done
);

  localparam logic [CNT_W-1:0] DRIVE_LIMIT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIMIT = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_DIGITS - 1);

  disp_state_t           state_reg, state_next;
  logic [SEL_W-1:0]      sel_reg, sel_next;
  logic [WORD_W-1:0]     d_out_reg;
  logic [WORD_W-1:0]     pend_reg;
  logic                  pending_reg;
  logic                  frame_done_reg;
  logic                  swap;
  logic                  tmr_done;
  logic [CNT_W-1:0]      tmr_limit;
  logic [NUM_DIGITS-1:0] lz_ok;
  logic                  digit_on;

  assign tmr_limit = (state_reg == ST_DRIVE) ? DRIVE_LIMIT : BLANK_LIMIT;

  disp_interval_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  // Digit k is suppressed while nibbles 7..k of the displayed word are all zero.
`ifdef LZ_BLANK_EN
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == 0) begin : g_first
      assign lz_ok[gi] = 1'b1;
    end else begin : g_upper
      assign lz_ok[gi] = |d_out_reg[WORD_W-1:gi*NIBBLE_W];
    end
  end
`else
  assign lz_ok = '1;
`endif

  assign digit_on = dig_en[sel_reg] & lz_ok[sel_reg];

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    swap       = 1'b0;
    anode      = ANODE_OFF;
    case (state_reg)
      ST_BLANK: begin
        if (tmr_done) begin
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (digit_on) begin
          anode = anode_for(sel_reg);
        end
        if (tmr_done) begin
          state_next = ST_BLANK;
          sel_next   = sel_reg + SEL_W'(1);
          swap       = (sel_reg == LAST_SEL);
        end
      end
      default: begin
        state_next = ST_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_BLANK;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
    end
  end

  // Swap consumes the old pending word; a simultaneous load refills the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out_reg      <= '0;
      pend_reg       <= '0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= swap;
      if (swap && pending_reg) begin
        d_out_reg <= pend_reg;
      end
      if (data_load) begin
        pend_reg    <= data_in;
        pending_reg <= 1'b1;
      end else if (swap) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign sel        = sel_reg;
  assign d_out      = d_out_reg;
  assign pending    = pending_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_disp_scan_controller.sv
// Self-checking bench for disp_scan_controller with REFRESH_DIV=4, BLANK_CYCLES=2.
module tb_disp_scan_controller;

  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        data_load;
  logic [7:0]  dig_en;
  logic [2:0]  sel;
  logic [31:0] d_out;
  logic [7:0]  anode;
  logic        pending;
  logic        frame_done;

  disp_scan_controller #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .CNT_W        (17)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_load  (data_load),
    .dig_en     (dig_en),
    .sel        (sel),
    .d_out      (d_out),
    .anode      (anode),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          t;
  logic [31:0] mdisp, mword;
  bit          mpend;

  typedef struct {
    logic [7:0] exp_anode;
    logic [2:0] exp_sel;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    end
  endtask

  // Expected outputs derived from the position within the 48-cycle frame.
  task automatic compare_all();
    int p, seg;
    bit blank, en_ok;
    logic [7:0] exp_an;
    p     = t % FRAME;
    seg   = p / SLOT;
    blank = (p % SLOT) < BC;
    en_ok = dig_en[seg];
`ifdef LZ_BLANK_EN
    if (seg != 0 && (mdisp >> (4 * seg)) == 0) en_ok = 1'b0;
`endif
    exp_an = (!blank && en_ok) ? ~(8'h01 << seg) : 8'hFF;
    check("sel", 32'(sel), 32'(seg));
    check("anode", 32'(anode), 32'(exp_an));
    check("d_out", d_out, mdisp);
    check("pending", 32'(pending), 32'(mpend));
    check("frame_done", 32'(frame_done), 32'((p == 0 && t > 0) ? 1 : 0));
  endtask

  task automatic cycle(input logic ld, input logic [31:0] d);
    bit swap;
    data_load = ld;
    data_in   = d;
    @(posedge clk);
    swap = (t % FRAME) == FRAME - 1;
    if (swap && mpend) begin
      mdisp = mword;
      mpend = 1'b0;
    end
    if (ld) begin
      mword = d;
      mpend = 1'b1;
    end
    t++;
    @(negedge clk);
    data_load = 1'b0;
    compare_all();
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) cycle(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    t = 0; mpend = 1'b0; mdisp = '0; mword = '0;
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    int fd_cnt;
    logic [31:0] rnd;
    reset = 1'b1; data_load = 1'b0; data_in = '0; dig_en = 8'hFF; t = 0;

    // Cycle-by-cycle anode/sel sequence just after reset.
    tbl[0] = '{8'hFF, 3'd0}; tbl[1] = '{8'hFF, 3'd0};
    tbl[2] = '{8'hFE, 3'd0}; tbl[3] = '{8'hFE, 3'd0};
    tbl[4] = '{8'hFE, 3'd0}; tbl[5] = '{8'hFE, 3'd0};
    tbl[6] = '{8'hFF, 3'd1}; tbl[7] = '{8'hFF, 3'd1};
`ifdef LZ_BLANK_EN
    tbl[8] = '{8'hFF, 3'd1}; tbl[9] = '{8'hFF, 3'd1};
`else
    tbl[8] = '{8'hFD, 3'd1}; tbl[9] = '{8'hFD, 3'd1};
`endif

    do_reset();
    check("tbl_anode", 32'(anode), 32'(tbl[0].exp_anode));
    check("tbl_sel", 32'(sel), 32'(tbl[0].exp_sel));
    for (int k = 1; k < 10; k++) begin
      cycle(1'b0, 32'h0);
      check("tbl_anode", 32'(anode), 32'(tbl[k].exp_anode));
      check("tbl_sel", 32'(sel), 32'(tbl[k].exp_sel));
    end

    // Two free-running frames: exactly two frame_done pulses.
    fd_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 32'h0);
      if (frame_done) fd_cnt++;
    end
    check("fd_count", 32'(fd_cnt), 32'd2);

    // Load at sel 3; held pending until the frame swap.
    run_to(3 * SLOT + BC);
    cycle(1'b1, 32'h1234_5678);
    check("pend_held", 32'(pending), 32'd1);
    check("dout_held", d_out, 32'h0);
    run_to(1);
    check("dout_swapped", d_out, 32'h1234_5678);
    check("pend_clear", 32'(pending), 32'd0);

    // Load A, then load B in the swap cycle.
    run_to(20);
    cycle(1'b1, 32'hAAAA_0001);
    run_to(FRAME - 1);
    cycle(1'b1, 32'hBBBB_0002);
    check("swapA_dout", d_out, 32'hAAAA_0001);
    check("swapA_pend", 32'(pending), 32'd1);
    for (int i = 0; i < FRAME; i++) cycle(1'b0, 32'h0);
    check("swapB_dout", d_out, 32'hBBBB_0002);
    check("swapB_pend", 32'(pending), 32'd0);

    // Upper digits disabled, then async reset during DRIVE at sel 5.
    dig_en = 8'h0F;
    for (int i = 0; i < FRAME; i++) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'hCAFE_F00D);
    run_to(5 * SLOT + BC + 1);
    dig_en = 8'hFF;
    #1 check("pre_rst_anode", 32'(anode), 32'hDF);
    reset = 1'b1;
    #1;
    check("rst_anode", 32'(anode), 32'hFF);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_dout", d_out, 32'h0);
    do_reset();

    // Leading-zero words.
    cycle(1'b1, 32'h0000_00A3);
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h0);
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b0, 32'h0);

    // Randomized traffic against the frame-position model.
    for (int i = 0; i < 900; i++) begin
      rnd = $urandom >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) dig_en = 8'($urandom);
      if ((t % FRAME) == FRAME - 1) cycle(1'($urandom_range(0, 1)), rnd);
      else cycle($urandom_range(0, 9) == 0, rnd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
